// File: rtl/rf_write_arbiter.sv
// Two-source register-file write arbiter: per-source 2-entry queues, oldest-first
// issue by enqueue stamp, registered RF write port and pending-write lookup.

module rf_write_queue #(
    parameter int AWL   = 5,
    parameter int DWL   = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enq,
    input  logic           deq,
    input  logic [AWL-1:0] wa,
    input  logic [DWL-1:0] wd,
    input  logic [2:0]     ws,
    input  logic [AWL-1:0] ra1,
    input  logic [AWL-1:0] ra2,
    output logic           ne,
    output logic           full,
    output logic [AWL-1:0] ha,
    output logic [DWL-1:0] hd,
    output logic [2:0]     hs,
    output logic           hit1,
    output logic           hit2
);
    logic [1:0][AWL-1:0] addr;
    logic [1:0][DWL-1:0] data;
    logic [1:0][2:0]     stamp;
    logic [1:0]          cnt;
    logic [1:0]          wpos;

    // Slot 0 is always the head; a dequeue shifts slot 1 down before the write lands.
    assign wpos = cnt - {1'b0, deq};
    assign ne   = (cnt != 2'd0);
    assign full = (cnt == 2'(DEPTH));
    assign ha   = addr[0];
    assign hd   = data[0];
    assign hs   = stamp[0];
    assign hit1 = (ne && addr[0] == ra1) || (cnt[1] && addr[1] == ra1);
    assign hit2 = (ne && addr[0] == ra2) || (cnt[1] && addr[1] == ra2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            data  <= '0;
            stamp <= '0;
            cnt   <= 2'd0;
        end else begin
            if (deq) begin
                addr[0]  <= addr[1];
                data[0]  <= data[1];
                stamp[0] <= stamp[1];
            end
            if (enq) begin
                addr[wpos[0]]  <= wa;
                data[wpos[0]]  <= wd;
                stamp[wpos[0]] <= ws;
            end
            cnt <= cnt + {1'b0, enq} - {1'b0, deq};
        end
    end
endmodule

module rf_write_arbiter #(
    parameter int AWL    = 5,
    parameter int DWL    = 32,
    parameter int QDEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [AWL-1:0] a_addr,
    input  logic [DWL-1:0] a_data,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [AWL-1:0] b_addr,
    input  logic [DWL-1:0] b_data,
    output logic           rfwe,
    output logic [AWL-1:0] rfwa,
    output logic [DWL-1:0] rfwd,
    input  logic [AWL-1:0] rfra1,
    input  logic [AWL-1:0] rfra2,
    output logic           pend1,
    output logic           pend2
);
    // Index 0 is source A (ALU), index 1 is source B (load).
    logic [1:0]          vld, rdy, enq, deq, ne, full, hit1, hit2;
    logic [1:0][AWL-1:0] wa, ha;
    logic [1:0][DWL-1:0] wd, hd;
    logic [1:0][2:0]     hs;
    logic [2:0]          stamp, age;
    logic                win_a, issue;

    assign vld = {b_valid, a_valid};
    assign wa  = {b_addr, a_addr};
    assign wd  = {b_data, a_data};
    assign rdy = {2{rst_n}} & ~full;
    assign enq = vld & rdy;
    assign a_ready = rdy[0];
    assign b_ready = rdy[1];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_q
            rf_write_queue #(.AWL(AWL), .DWL(DWL), .DEPTH(QDEPTH)) u_q (
                .clk(clk), .rst_n(rst_n), .enq(enq[g]), .deq(deq[g]),
                .wa(wa[g]), .wd(wd[g]), .ws(stamp), .ra1(rfra1), .ra2(rfra2),
                .ne(ne[g]), .full(full[g]), .ha(ha[g]), .hd(hd[g]), .hs(hs[g]),
                .hit1(hit1[g]), .hit2(hit2[g])
            );
        end
    endgenerate

    // At most four entries are in flight, so live stamps never span more than
    // half the 3-bit circle and the modular difference orders them correctly.
    assign age   = hs[1] - hs[0];
    assign win_a = ne[0] && (!ne[1] || !age[2]);
    assign issue = |ne;
    assign deq   = {issue && !win_a, win_a};

    assign pend1 = |hit1 || (rfwe && rfwa == rfra1);
    assign pend2 = |hit2 || (rfwe && rfwa == rfra2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp <= 3'd0;
            rfwe  <= 1'b0;
            rfwa  <= '0;
            rfwd  <= '0;
        end else begin
            if (|enq) stamp <= stamp + 3'd1;
            rfwe <= issue;
            if (issue) begin
                rfwa <= win_a ? ha[0] : ha[1];
                rfwd <= win_a ? hd[0] : hd[1];
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, tie, backpressure,
// stamp wrap and asynchronous mid-stream reset.
`timescale 1ns/100ps

module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, rfwa, rfra1, rfra2;
    logic [31:0] a_data, b_data, rfwd;
    logic        rfwe, pend1, pend2;
    int          nrun = 0;
    int          nfail = 0;

    rf_write_arbiter #(.AWL(5), .DWL(32), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd),
        .rfra1(rfra1), .rfra2(rfra2), .pend1(pend1), .pend2(pend2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 0; b_valid = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    endtask

    task automatic test_reset;
        #12;
        nrun++;
        if ({rfwe, rfwa, rfwd, a_ready, b_ready, pend1, pend2} !== '0) begin
            nfail++;
            $display("FAIL reset_state: got we=%0b wa=%0d wd=%h ar=%0b br=%0b p=%0b%0b, need all 0",
                     rfwe, rfwa, rfwd, a_ready, b_ready, pend1, pend2);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        nrun++;
        if ({a_ready, b_ready} !== 2'b11) begin
            nfail++;
            $display("FAIL reset_release_ready: got %b need 11", {a_ready, b_ready});
        end
    endtask

    task automatic test_single;
        a_valid = 1; a_addr = 3; a_data = 32'h11; rfra1 = 3;
        tick();
        a_valid = 0;
        nrun++;
        if (rfwe !== 1'b0 || pend1 !== 1'b1) begin
            nfail++;
            $display("FAIL single_queued: got we=%0b pend1=%0b need we=0 pend1=1", rfwe, pend1);
        end
        tick();
        nrun++;
        if (rfwe !== 1'b1 || rfwa !== 5'd3 || rfwd !== 32'h11) begin
            nfail++;
            $display("FAIL single_write: got we=%0b wa=%0d wd=%h need 1/3/11", rfwe, rfwa, rfwd);
        end
        tick();
        nrun++;
        if (rfwe !== 1'b0 || rfwa !== 5'd3 || rfwd !== 32'h11 || pend1 !== 1'b0) begin
            nfail++;
            $display("FAIL single_after: got we=%0b wa=%0d wd=%h p1=%0b need 0/3/11/0",
                     rfwe, rfwa, rfwd, pend1);
        end
    endtask

    task automatic test_addr0;
        b_valid = 1; b_addr = 0; b_data = 32'h22; rfra2 = 0;
        tick();
        b_valid = 0;
        nrun++;
        if (pend2 !== 1'b1) begin
            nfail++;
            $display("FAIL addr0_pend: got %0b need 1", pend2);
        end
        tick();
        nrun++;
        if (rfwe !== 1'b1 || rfwa !== 5'd0 || rfwd !== 32'h22) begin
            nfail++;
            $display("FAIL addr0_write: got we=%0b wa=%0d wd=%h need 1/0/22", rfwe, rfwa, rfwd);
        end
        tick();
        rfra2 = 31;
    endtask

    task automatic test_tie;
        logic [31:0] exp_d[2];
        logic        exp_p[4];
        exp_d[0] = 32'hAA; exp_d[1] = 32'hBB;
        exp_p[0] = 1; exp_p[1] = 1; exp_p[2] = 1; exp_p[3] = 0;
        a_valid = 1; a_addr = 5; a_data = 32'hAA;
        b_valid = 1; b_addr = 5; b_data = 32'hBB;
        rfra1 = 5;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            nrun++;
            if (pend1 !== exp_p[i]) begin
                nfail++;
                $display("FAIL tie_pend1[%0d]: got %0b need %0b", i, pend1, exp_p[i]);
            end
            tick();
            if (i < 2) begin
                nrun++;
                if (rfwe !== 1'b1 || rfwa !== 5'd5 || rfwd !== exp_d[i]) begin
                    nfail++;
                    $display("FAIL tie_write[%0d]: got we=%0b wa=%0d wd=%h need 1/5/%h",
                             i, rfwe, rfwa, rfwd, exp_d[i]);
                end
            end
        end
        rfra1 = 31;
    endtask

    task automatic test_backpressure;
        logic [31:0] got[$];
        logic [31:0] exp_d[6];
        int          acnt = 0, bcnt = 0;
        logic        ra, rb;
        exp_d[0] = 32'hA0; exp_d[1] = 32'hB0; exp_d[2] = 32'hA1;
        exp_d[3] = 32'hB1; exp_d[4] = 32'hA2; exp_d[5] = 32'hB2;
        a_addr = 10; b_addr = 20;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_valid = (cyc < 4); b_valid = (cyc < 4);
            a_data = 32'hA0 + acnt; b_data = 32'hB0 + bcnt;
            ra = a_ready; rb = b_ready;
            tick();
            if (a_valid && ra) acnt++;
            if (b_valid && rb) bcnt++;
            if (rfwe) got.push_back(rfwd);
            if (cyc == 1) begin
                nrun++;
                if (b_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL bp_b_full: got b_ready=%0b need 0", b_ready);
                end
            end
        end
        idle_inputs();
        nrun++;
        if (got.size() != 6) begin
            nfail++;
            $display("FAIL bp_count: got %0d writes need 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            nrun++;
            if (got[i] !== exp_d[i]) begin
                nfail++;
                $display("FAIL bp_order[%0d]: got %h need %h", i, got[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] got[$];
        int          k = 0;
        int          budget = 0;
        logic        ra, rb;
        while ((k < 20 || got.size() < 20) && budget < 300) begin
            budget++;
            idle_inputs();
            if (k < 20 && $urandom_range(0, 2) != 0) begin
                if (k % 2 == 0) begin
                    a_valid = 1; a_addr = 5'(k % 3); a_data = 32'h100 + k;
                end else begin
                    b_valid = 1; b_addr = 5'(k % 3); b_data = 32'h100 + k;
                end
            end
            ra = a_ready; rb = b_ready;
            tick();
            if ((a_valid && ra) || (b_valid && rb)) k++;
            if (rfwe) got.push_back(rfwd);
        end
        idle_inputs();
        nrun++;
        if (got.size() != 20) begin
            nfail++;
            $display("FAIL wrap_count: got %0d writes need 20 (budget %0d)", got.size(), budget);
        end
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            nrun++;
            if (got[i] !== 32'h100 + i) begin
                nfail++;
                $display("FAIL wrap_order[%0d]: got %h need %h", i, got[i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_reset_mid;
        a_valid = 1; a_addr = 7; b_valid = 1; b_addr = 8;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'hC0 + i; b_data = 32'hD0 + i;
            tick();
        end
        idle_inputs();
        rfra1 = 7;
        nrun++;
        if (a_ready !== 1'b0 || rfwe !== 1'b1) begin
            nfail++;
            $display("FAIL rmid_full: got ar=%0b we=%0b need 0/1", a_ready, rfwe);
        end
        #1 rst_n = 0;
        #1;
        nrun++;
        if (rfwe !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || pend1 !== 1'b0) begin
            nfail++;
            $display("FAIL rmid_async: got we=%0b ar=%0b br=%0b p1=%0b need 0",
                     rfwe, a_ready, b_ready, pend1);
        end
        rst_n = 1;
        tick();
        nrun++;
        if ({a_ready, b_ready} !== 2'b11) begin
            nfail++;
            $display("FAIL rmid_ready: got %b need 11", {a_ready, b_ready});
        end
        for (int i = 0; i < 4; i++) begin
            nrun++;
            if (rfwe !== 1'b0) begin
                nfail++;
                $display("FAIL rmid_no_write[%0d]: got we=%0b wd=%h need 0", i, rfwe, rfwd);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        rfra1 = 31; rfra2 = 31;
        test_reset();
        test_single();
        test_addr0();
        test_tie();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter AWL, default 5: register address width; must equal the register file write/read address width.
REQ-002 Parameter DWL, default 32: register data width.
REQ-003 Parameter QDEPTH, fixed 2: entries per source queue.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 A_VALID  input  1  source A (ALU writeback) write request.
REQ-007 A_READY  output  1  queue A can accept this cycle.
REQ-008 A_ADDR  input  AWL  source A destination register.
REQ-009 A_DATA  input  DWL  source A write data.
REQ-010 B_VALID, B_READY, B_ADDR, B_DATA: same as REQ-006..009, for source B (load writeback).
REQ-011 RFWE  output  1  register file write enable, registered.
REQ-012 RFWA  output  AWL  register file write address, registered.
REQ-013 RFWD  output  DWL  register file write data, registered.
REQ-014 RFRA1, RFRA2  input  AWL  read addresses to be checked for pending writes.
REQ-015 PEND1, PEND2  output  1  combinational; a write to RFRA1/RFRA2 is still outstanding.

Function
REQ-016 Each source has a private FIFO of QDEPTH entries; each entry holds {addr, data, 3-bit stamp}.
REQ-017 X_READY = queue X not full; depends on state only, never on X_VALID.
REQ-018 Enqueue on the rising edge where X_VALID and X_READY are both high; X_VALID while not ready is ignored, with no side effect.
REQ-019 Stamp counter: 3 bits; increments by 1 on every edge with at least one enqueue; wraps 7 -> 0; A and B enqueued on the same edge receive the same stamp.
REQ-020 Each cycle with at least one queue non-empty, exactly one head is issued: the older head wins.
REQ-021 A is older-or-equal iff ((stampB - stampA) mod 8) < 4; on equal stamps A wins. Heads of different ages always issue oldest-first, across both queues.
REQ-022 Issue: the winner's addr/data load into RFWA/RFWD and RFWE=1 on the next rising edge, and its entry dequeues on the same edge; latency is 1 edge after enqueue at minimum.
REQ-023 No issue in a cycle: RFWE=0 on the next edge; RFWA/RFWD hold their previous values.
REQ-024 Sustained throughput: one write per cycle; a queue may enqueue and dequeue on the same edge, and full-with-dequeue still reports READY=0 (no pass-through).
REQ-025 Program order: writes to the same address reach RFWE in enqueue order, with A before B on same-edge ties.
REQ-026 PENDn = RFRAn matches any valid entry in either queue, or (RFWE==1 and RFWA==RFRAn).
REQ-027 Address 0 gets no special treatment; it is queued and written like any other address.

Reset
REQ-028 While RST_N=0: both queues empty, stamp=0, RFWE=0, RFWA=0, RFWD=0, A_READY=B_READY=0, PEND1=PEND2=0.
REQ-029 Reset mid-operation discards all queued and issuing writes immediately, without waiting for a clock edge; no RFWE pulse follows the release.
REQ-030 The first rising edge after RST_N rises leaves A_READY=B_READY=1.

Verification
REQ-031 Single A request: A addr=3, data=0x11 for 1 cycle -> RFWE=1, RFWA=3, RFWD=0x11 exactly one cycle after the enqueue edge, then RFWE=0.
REQ-032 Same-edge tie: A (5, 0xAA) and B (5, 0xBB) together -> RFWD 0xAA then 0xBB on consecutive cycles; PEND1 (RFRA1=5) high until the cycle after the 0xBB write.
REQ-033 Backpressure: hold B_VALID for 4 cycles with the A queue active -> B_READY=0 when full; exactly the accepted count of B writes appears, in order, with no duplicates.
REQ-034 Stamp wrap: 20 alternating A/B enqueues with random stalls -> RFWE sequence matches the global enqueue order, including across the 7 -> 0 wrap.
REQ-035 Reset mid-stream: queues full, RST_N=0 for 1 ns between edges -> RFWE=0 immediately, no write after release, READY=1 after the first edge.
